// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - single-neuron multiply-accumulate pre-activation stage
// Full-precision sum of x*w plus bias, rounded half up and saturated back to sfp.
module neuron_mac #(
   parameter int N_INPUTS = 4,
   parameter int W        = 16,
   parameter int FRAC     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic signed [W-1:0] bias,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] x_in,
   input  logic signed [W-1:0] w_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] z_out,
   output logic                sat,
   output logic                busy
);

   localparam int ACC_W = 2*W + $clog2(N_INPUTS) + 1;
   localparam int CW    = $clog2(N_INPUTS + 1);
   localparam logic signed [ACC_W-1:0] SFP_MAX  = ACC_W'((64'sd1 <<< (W-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SFP_MIN  = -SFP_MAX - ACC_W'(1);
   localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(64'sd1 <<< (FRAC-1));
   localparam logic [CW-1:0]           LAST     = CW'(N_INPUTS - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, FINISH, OUT} state_t;

   state_t                  state, next_state;
   logic signed [ACC_W-1:0] acc;
   logic [CW-1:0]           count;
   logic signed [2*W-1:0]   prod;
   logic signed [ACC_W-1:0] rnd;
   logic signed [ACC_W-1:0] r;
   logic                    take;

   assign prod = x_in * w_in;
   assign take = (state == ACCUM) && in_valid;
   assign rnd  = acc + HALF_LSB;
   assign r    = rnd >>> FRAC;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) next_state = ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && count == LAST) next_state = FINISH;
         end
         FINISH: next_state = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Bias enters pre-scaled by 2^FRAC so it lines up with the 2*FRAC product scaling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         count <= '0;
         z_out <= '0;
         sat   <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            acc   <= {{(ACC_W-W-FRAC){bias[W-1]}}, bias, {FRAC{1'b0}}};
            count <= '0;
         end else if (take) begin
            acc   <= acc + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
            count <= count + CW'(1);
         end
         if (state == FINISH) begin
            if (r > SFP_MAX) begin
               z_out <= SFP_MAX[W-1:0];
               sat   <= 1'b1;
            end else if (r < SFP_MIN) begin
               z_out <= SFP_MIN[W-1:0];
               sat   <= 1'b1;
            end else begin
               z_out <= r[W-1:0];
               sat   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - self-checking bench for neuron_mac
// Drives and samples on the falling edge; expectations come from an integer fixed-point model.
module tb_neuron_mac;

   localparam int N    = 4;
   localparam int W    = 16;
   localparam int FRAC = 8;
   localparam logic signed [W-1:0] MAXV = 16'sh7FFF;
   localparam logic signed [W-1:0] MINV = -16'sh8000;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic signed [W-1:0] bias = '0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic signed [W-1:0] x_in = '0;
   logic signed [W-1:0] w_in = '0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic signed [W-1:0] z_out;
   logic                sat;
   logic                busy;

   int checks = 0;
   int errors = 0;
   logic signed [W-1:0] xv [N];
   logic signed [W-1:0] wv [N];

   neuron_mac #(.N_INPUTS(N), .W(W), .FRAC(FRAC)) dut (
      .clk(clk), .rst(rst), .start(start), .bias(bias),
      .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
      .out_valid(out_valid), .out_ready(out_ready), .z_out(z_out),
      .sat(sat), .busy(busy)
   );

   always #5 clk = ~clk;

   // Real-number semantics: sum in units of 2^-2FRAC, round half up, clamp to sfp range.
   task automatic model(input logic signed [W-1:0] b, output logic signed [W-1:0] z, output logic s);
      longint acc, r;
      acc = longint'(b) * (longint'(1) << FRAC);
      for (int i = 0; i < N; i++) acc += longint'(xv[i]) * longint'(wv[i]);
      r = (acc + (longint'(1) << (FRAC-1))) >>> FRAC;
      if (r > 32767)       begin z = MAXV; s = 1'b1; end
      else if (r < -32768) begin z = MINV; s = 1'b1; end
      else                 begin z = W'(r); s = 1'b0; end
   endtask

   // Returns at the falling edge of the cycle after the last pair is accepted.
   task automatic feed(input logic signed [W-1:0] b, input bit bubbles, input bit noise);
      bit acc_now;
      int guard;
      @(negedge clk); start = 1'b1; bias = b; in_valid = 1'b0;
      @(negedge clk); start = 1'b0; bias = W'($urandom);
      for (int i = 0; i < N; i++) begin
         if (bubbles) begin
            in_valid = 1'b0;
            x_in = W'($urandom); w_in = W'($urandom);
            if (noise) start = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         in_valid = 1'b1; x_in = xv[i]; w_in = wv[i];
         if (noise) start = 1'($urandom_range(0, 1));
         acc_now = 1'b0; guard = 0;
         while (!acc_now && guard < 20) begin
            acc_now = in_ready;
            @(negedge clk);
            guard++;
         end
         if (!acc_now) begin
            checks++; errors++;
            $display("FAIL feed_timeout pair %0d: in_ready never high within 20 cycles", i);
         end
      end
      in_valid = noise; start = noise;
      x_in = W'($urandom); w_in = W'($urandom);
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
      checks++;
      if (!out_valid) begin errors++; $display("FAIL out_timeout: out_valid low after %0d cycles", cyc); end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({in_ready, out_valid, busy, sat} !== 4'b0 || z_out !== '0) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%b ov=%b busy=%b sat=%b z=%h, required all 0", in_ready, out_valid, busy, sat, z_out);
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_idle: busy=%b ov=%b, required 0 0", busy, out_valid);
      end
   endtask

   task automatic test_basic();
      xv = '{16'sd256, 16'sd512, -16'sd256, 16'sd128};
      wv = '{16'sd128, 16'sd64, 16'sd256, 16'sd512};
      feed(16'sd128, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL basic_finish: ov=%b busy=%b rdy=%b, required 0 1 0", out_valid, busy, in_ready);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || z_out !== 16'sd384 || sat !== 1'b0) begin
         errors++; $display("FAIL basic_result: ov=%b z=%0d sat=%b, required 1 384 0", out_valid, z_out, sat);
      end
      @(negedge clk); out_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL basic_idle: busy=%b ov=%b, required 0 0", busy, out_valid);
      end
   endtask

   task automatic test_bubbles_hold();
      int cyc;
      xv = '{16'sd256, 16'sd512, -16'sd256, 16'sd128};
      wv = '{16'sd128, 16'sd64, 16'sd256, 16'sd512};
      feed(16'sd128, 1'b1, 1'b0);
      wait_out(cyc);
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (out_valid !== 1'b1 || z_out !== 16'sd384 || in_ready !== 1'b0) begin
            errors++; $display("FAIL hold_cycle%0d: ov=%b z=%0d rdy=%b, required 1 384 0", k, out_valid, z_out, in_ready);
         end
         @(negedge clk);
      end
      handshake();
      checks++;
      if (out_valid !== 1'b0 || z_out !== 16'sd384) begin
         errors++; $display("FAIL hold_after: ov=%b z=%0d, required 0 384", out_valid, z_out);
      end
   endtask

   task automatic test_saturation();
      int cyc;
      for (int i = 0; i < N; i++) begin xv[i] = MAXV; wv[i] = MAXV; end
      feed(MAXV, 1'b0, 1'b0); wait_out(cyc);
      checks++;
      if (z_out !== MAXV || sat !== 1'b1) begin
         errors++; $display("FAIL sat_pos: z=%h sat=%b, required 7fff 1", z_out, sat);
      end
      handshake();
      for (int i = 0; i < N; i++) wv[i] = MINV;
      feed(MAXV, 1'b0, 1'b0); wait_out(cyc);
      checks++;
      if (z_out !== MINV || sat !== 1'b1) begin
         errors++; $display("FAIL sat_neg: z=%h sat=%b, required 8000 1", z_out, sat);
      end
      handshake();
   endtask

   task automatic test_rounding();
      int cyc;
      xv = '{16'sd1, 16'sd0, 16'sd0, 16'sd0};
      wv = '{16'sd128, 16'sd0, 16'sd0, 16'sd0};
      feed(16'sd0, 1'b0, 1'b0); wait_out(cyc);
      checks++;
      if (z_out !== 16'sd1 || sat !== 1'b0) begin
         errors++; $display("FAIL round_up: z=%0d sat=%b, required 1 0", z_out, sat);
      end
      handshake();
      wv[0] = -16'sd128;
      feed(16'sd0, 1'b0, 1'b0); wait_out(cyc);
      checks++;
      if (z_out !== 16'sd0 || sat !== 1'b0) begin
         errors++; $display("FAIL round_neg_half: z=%0d sat=%b, required 0 0", z_out, sat);
      end
      handshake();
   endtask

   task automatic test_reset_abort();
      int cyc;
      @(negedge clk); start = 1'b1; bias = 16'sd1000;
      @(negedge clk); start = 1'b0;
      in_valid = 1'b1; x_in = 16'sd3000; w_in = 16'sd2000;
      @(negedge clk); @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, out_valid, busy, sat} !== 4'b0 || z_out !== '0) begin
         errors++;
         $display("FAIL abort_reset: rdy=%b ov=%b busy=%b sat=%b z=%h, required all 0", in_ready, out_valid, busy, sat, z_out);
      end
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < N; i++) begin xv[i] = 16'sd256; wv[i] = 16'sd256; end
      feed(16'sd0, 1'b0, 1'b0); wait_out(cyc);
      checks++;
      if (z_out !== 16'sd1024 || sat !== 1'b0) begin
         errors++; $display("FAIL abort_fresh: z=%0d sat=%b, required 1024 0", z_out, sat);
      end
      handshake();
   endtask

   task automatic test_ignored_controls();
      int cyc;
      logic signed [W-1:0] ez, prev_z;
      logic es;
      prev_z = z_out;
      in_valid = 1'b1; x_in = 16'sd700; w_in = 16'sd700;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || busy !== 1'b0 || z_out !== prev_z) begin
            errors++; $display("FAIL idle_ignore%0d: rdy=%b busy=%b z=%0d, required 0 0 %0d", k, in_ready, busy, z_out, prev_z);
         end
      end
      in_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
         xv[i] = W'($urandom_range(0, 1023)) - 16'sd512;
         wv[i] = W'($urandom_range(0, 1023)) - 16'sd512;
      end
      model(16'sd77, ez, es);
      feed(16'sd77, 1'b1, 1'b1);
      wait_out(cyc);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (z_out !== ez || sat !== es) begin
            errors++; $display("FAIL noise_result%0d: z=%0d sat=%b, required %0d %b", k, z_out, sat, ez, es);
         end
         @(negedge clk);
      end
      start = 1'b1; in_valid = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
      checks++;
      if (busy !== 1'b0 || z_out !== ez) begin
         errors++; $display("FAIL start_in_out: busy=%b z=%0d, required 0 %0d", busy, z_out, ez);
      end
   endtask

   task automatic test_random();
      int cyc, hold;
      logic signed [W-1:0] b, ez;
      logic es;
      for (int t = 0; t < 10; t++) begin
         for (int i = 0; i < N; i++) begin
            xv[i] = (t < 3) ? W'($urandom) : W'($urandom_range(0, 4095)) - 16'sd2048;
            wv[i] = (t < 3) ? W'($urandom) : W'($urandom_range(0, 4095)) - 16'sd2048;
         end
         b = W'($urandom);
         model(b, ez, es);
         feed(b, 1'($urandom_range(0, 1)), 1'b0);
         wait_out(cyc);
         checks++;
         if (cyc !== 1) begin
            errors++; $display("FAIL rand%0d_latency: %0d cycles after FINISH, required 1", t, cyc);
         end
         hold = $urandom_range(0, 3);
         for (int k = 0; k <= hold; k++) begin
            checks++;
            if (out_valid !== 1'b1 || z_out !== ez || sat !== es) begin
               errors++; $display("FAIL rand%0d_result: ov=%b z=%0d sat=%b, required 1 %0d %b", t, out_valid, z_out, sat, ez, es);
            end
            if (k < hold) @(negedge clk);
         end
         handshake();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bubbles_hold();
      test_saturation();
      test_rounding();
      test_reset_abort();
      test_ignored_controls();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
